// File: rtl/biriscv_v_issue_if.sv
// ---------------------------------------------------------------------------
// biriscv_v_issue_if
// Bundles the three buses of the vector issue unit:
//   issue_*      : decoded instruction offered by the issue stage (+ hold_i stall)
//   opcode_*     : registered op and operands presented to the vector exec unit
//   writeback_*  : in-order results returning from the exec unit
//   wb_error_o   : sticky flag for a writeback with nothing in flight
// slave  modport : the issue unit itself
// master modport : the surrounding core / exec unit (or a testbench)
// ---------------------------------------------------------------------------
interface biriscv_v_issue_if #(
    parameter int VLEN = 128
);
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [31:0]     issue_opcode_i;
    logic [31:0]     issue_pc_i;
    logic [31:0]     issue_ra_operand_i;
    logic [31:0]     issue_rb_operand_i;
    logic            hold_i;

    logic            opcode_valid_o;
    logic [31:0]     opcode_opcode_o;
    logic [31:0]     opcode_pc_o;
    logic [4:0]      opcode_vd_idx_o;
    logic [4:0]      opcode_va_idx_o;
    logic [4:0]      opcode_vb_idx_o;
    logic [31:0]     opcode_ra_operand_o;
    logic [31:0]     opcode_rb_operand_o;
    logic [VLEN-1:0] opcode_va_operand_o;
    logic [VLEN-1:0] opcode_vb_operand_o;
    logic [VLEN-1:0] opcode_vmask_operand_o;

    logic            writeback_valid_i;
    logic [VLEN-1:0] writeback_value_i;
    logic            wb_error_o;

    modport slave (
        input  issue_valid_i, issue_opcode_i, issue_pc_i,
               issue_ra_operand_i, issue_rb_operand_i, hold_i,
               writeback_valid_i, writeback_value_i,
        output issue_ready_o,
               opcode_valid_o, opcode_opcode_o, opcode_pc_o,
               opcode_vd_idx_o, opcode_va_idx_o, opcode_vb_idx_o,
               opcode_ra_operand_o, opcode_rb_operand_o,
               opcode_va_operand_o, opcode_vb_operand_o, opcode_vmask_operand_o,
               wb_error_o
    );

    modport master (
        output issue_valid_i, issue_opcode_i, issue_pc_i,
               issue_ra_operand_i, issue_rb_operand_i, hold_i,
               writeback_valid_i, writeback_value_i,
        input  issue_ready_o,
               opcode_valid_o, opcode_opcode_o, opcode_pc_o,
               opcode_vd_idx_o, opcode_va_idx_o, opcode_vb_idx_o,
               opcode_ra_operand_o, opcode_rb_operand_o,
               opcode_va_operand_o, opcode_vb_operand_o, opcode_vmask_operand_o,
               wb_error_o
    );
endinterface

// File: rtl/biriscv_v_issue.sv
// ---------------------------------------------------------------------------
// biriscv_v_issue
// Vector issue / operand-supply unit. Holds the 32 x VLEN vector register
// file, blocks RAW/WAW hazards with a per-register pending scoreboard, drives
// the registered op + operands to the vector exec unit and commits in-order
// writebacks using a FIFO of pending destination indices.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous, active-high reset
//   bus    : biriscv_v_issue_if.slave (issue, opcode, writeback, wb_error)
// ---------------------------------------------------------------------------
module biriscv_v_issue #(
    parameter int VLEN     = 128,
    parameter int WB_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    biriscv_v_issue_if.slave      bus
);
    localparam int PTR_W = $clog2(WB_DEPTH);

    logic [VLEN-1:0] regs [32];
    logic [31:0]     pend;
    logic [31:0]     pend_next;
    logic [4:0]      fifo_mem [WB_DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;

    logic [4:0]      vd;
    logic [4:0]      vs1;
    logic [4:0]      vs2;
    logic            vm;
    logic            fifo_full;
    logic            fifo_empty;
    logic [4:0]      head;
    logic            accept;
    logic            wb_fire;

    assign vd  = bus.issue_opcode_i[11:7];
    assign vs1 = bus.issue_opcode_i[19:15];
    assign vs2 = bus.issue_opcode_i[24:20];
    assign vm  = bus.issue_opcode_i[25];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_full  = (wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}};
    assign fifo_empty = wr_ptr == rd_ptr;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    // v0 is only a hazard when the op is masked (vm = 0).
    assign bus.issue_ready_o = ~bus.hold_i & ~fifo_full & ~pend[vs1] & ~pend[vs2]
                             & ~pend[vd] & (vm | ~pend[0]);

    assign accept  = bus.issue_valid_i & bus.issue_ready_o;
    assign wb_fire = bus.writeback_valid_i & ~fifo_empty;

    // Register file commit; writeback is deliberately not gated by hold_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_fire) begin
            regs[head] <= bus.writeback_value_i;
        end
    end

    // Storage for pending destinations; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (accept) fifo_mem[wr_ptr[PTR_W-1:0]] <= vd;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept)  wr_ptr <= wr_ptr + 1'b1;
            if (wb_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Clear for the committing head first, then set for a new accept, so a
    // same-register collision resolves in favour of the set.
    always_comb begin
        pend_next = pend;
        if (wb_fire) pend_next[head] = 1'b0;
        if (accept)  pend_next[vd]   = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pend <= '0;
        else       pend <= pend_next;
    end

    // A commit and a new accept to the same register should be impossible,
    // since the pending bit blocks that accept.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(accept && wb_fire && head == vd));
        end
    end

    // Operand stage: load on accept, drop valid when idle, freeze on hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.opcode_valid_o         <= 1'b0;
            bus.opcode_opcode_o        <= '0;
            bus.opcode_pc_o            <= '0;
            bus.opcode_vd_idx_o        <= '0;
            bus.opcode_va_idx_o        <= '0;
            bus.opcode_vb_idx_o        <= '0;
            bus.opcode_ra_operand_o    <= '0;
            bus.opcode_rb_operand_o    <= '0;
            bus.opcode_va_operand_o    <= '0;
            bus.opcode_vb_operand_o    <= '0;
            bus.opcode_vmask_operand_o <= '0;
        end else if (accept) begin
            bus.opcode_valid_o         <= 1'b1;
            bus.opcode_opcode_o        <= bus.issue_opcode_i;
            bus.opcode_pc_o            <= bus.issue_pc_i;
            bus.opcode_vd_idx_o        <= vd;
            bus.opcode_va_idx_o        <= vs1;
            bus.opcode_vb_idx_o        <= vs2;
            bus.opcode_ra_operand_o    <= bus.issue_ra_operand_i;
            bus.opcode_rb_operand_o    <= bus.issue_rb_operand_i;
            bus.opcode_va_operand_o    <= regs[vs1];
            bus.opcode_vb_operand_o    <= regs[vs2];
            bus.opcode_vmask_operand_o <= regs[0];
        end else if (!bus.hold_i) begin
            bus.opcode_valid_o         <= 1'b0;
        end
    end

    // Sticky error: a result came back with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                  bus.wb_error_o <= 1'b0;
        else if (bus.writeback_valid_i && fifo_empty) bus.wb_error_o <= 1'b1;
    end
endmodule
